sdm_decimator: RTL and testbench

//   Receive-side counterpart of the 1-bit sigma-delta dac. Accepts a 1-bit

---
 rtl/sdm_decimator.sv | 129 ++++++++++++
 tb/tb_sdm_decimator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sdm_decimator.sv
// 3rd-order CIC decimator: 1-bit sigma-delta bitstream in, signed 16-bit PCM out.
// Latency: dout_valid rises on the second edge counted from the decimation strobe edge; first valid is edge 4*DECIM+1 after reset.
// Backpressure: none; one bitstream sample is consumed every cycle and dout_valid is a free-running strobe at clk/DECIM.
module sdm_decimator #(
  parameter int LOG2_DECIM = 6,
  parameter int ACC_W      = 3*LOG2_DECIM+2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic [15:0] dout,
  output logic        dout_valid
);

  // Net shift that normalises the CIC gain DECIM**3 to 2**15 full scale.
  localparam int SH  = 3*LOG2_DECIM - 15;
  // Wide enough to hold ycomb after the largest left shift (LOG2_DECIM=2).
  localparam int W_S = ACC_W + 16;
  localparam logic signed [W_S-1:0] MAXV = W_S'(32767);
  localparam logic signed [W_S-1:0] MINV = ~MAXV;

  logic [ACC_W-1:0]      r_i1, r_i2, r_i3;
  logic [ACC_W-1:0]      r_d1, r_d2, r_d3;
  logic [ACC_W-1:0]      r_ycomb;
  logic [LOG2_DECIM-1:0] r_cnt;
  logic [1:0]            r_warm;
  logic                  r_ypend;

  logic [ACC_W-1:0]      w_x;
  logic [ACC_W-1:0]      w_c1, w_c2, w_c3;
  logic                  w_strobe;
  logic signed [W_S-1:0] w_ext;
  logic signed [W_S-1:0] w_scaled;
  logic [15:0]           w_sat;

  assign w_x      = din ? ACC_W'(1) : '1;
  // Counter sits at DECIM-1 exactly when all bits are set.
  assign w_strobe = &r_cnt;
  assign w_c1     = r_i3 - r_d1;
  assign w_c2     = w_c1 - r_d2;
  assign w_c3     = w_c2 - r_d3;
  assign w_ext    = {{(W_S-ACC_W){r_ycomb[ACC_W-1]}}, r_ycomb};

  generate
    if (SH >= 0) begin : g_shr
      assign w_scaled = w_ext >>> SH;
    end else begin : g_shl
      assign w_scaled = w_ext <<< (-SH);
    end
  endgenerate

  // Clamp the scaled comb result into the signed 16-bit range.
  always_comb begin
    w_sat = w_scaled[15:0];
    if (w_scaled > MAXV) begin
      w_sat = 16'h7fff;
    end else if (w_scaled < MINV) begin
      w_sat = 16'h8000;
    end
  end

  // Integrator chain; all three stages advance together and wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i1 <= '0;
      r_i2 <= '0;
      r_i3 <= '0;
    end else begin
      r_i1 <= r_i1 + w_x;
      r_i2 <= r_i2 + r_i1;
      r_i3 <= r_i3 + r_i2;
    end
  end

  // Decimation phase counter; wraps naturally at DECIM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Comb section runs once per output sample at the decimated rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d1    <= '0;
      r_d2    <= '0;
      r_d3    <= '0;
      r_ycomb <= '0;
    end else if (w_strobe) begin
      r_d1    <= r_i3;
      r_d2    <= w_c1;
      r_d3    <= w_c2;
      r_ycomb <= w_c3;
    end
  end

  // Suppress the first three comb results, then flag each new one for output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warm  <= '0;
      r_ypend <= 1'b0;
    end else if (w_strobe) begin
      if (r_warm == 2'd3) begin
        r_ypend <= 1'b1;
      end else begin
        r_warm  <= r_warm + 2'd1;
        r_ypend <= 1'b0;
      end
    end else begin
      r_ypend <= 1'b0;
    end
  end

  // Output register: update and strobe only when a settled sample is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= r_ypend;
      if (r_ypend) begin
        dout <= w_sat;
      end
    end
  end

endmodule

// File: tb/tb_sdm_decimator.sv
// Bench for sdm_decimator: two instances (DECIM 64 and DECIM 16) share one bitstream.
// Reference is a cascade of three length-DECIM moving sums sampled at edge k*DECIM+1.
// Literal checks pin steady-state values, first-valid edge and strobe spacing.
module tb_sdm_decimator;

  logic        clk;
  logic        rst_n;
  logic        din;
  logic [15:0] dout6, dout4;
  logic        vld6, vld4;

  int n_tests;
  int n_fail;

  localparam int L2[2]    = '{6, 4};
  localparam int DEC[2]   = '{64, 16};
  localparam int FIRST[2] = '{257, 65};

  sdm_decimator #(.LOG2_DECIM(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(dout6), .dout_valid(vld6));
  sdm_decimator #(.LOG2_DECIM(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(dout4), .dout_valid(vld4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  longint xr [2][1024];
  longint m1r[2][1024];
  longint m2r[2][1024];
  longint m3r[2][1024];
  int     t;
  int     exp_dout[2];
  logic   exp_vld[2];
  // Observation state used by the literal checks
  int     last_vdout[2];
  logic   seen[2];
  int     last_vt[2];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, exp, t);
    end
  endtask

  function automatic int scale16(input longint y, input int l2);
    longint num, den, q;
    num = y * 32768;
    den = longint'(1) << (3*l2);
    q   = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  // Reference model: cascaded moving sums of the +/-1 input stream.
  initial begin
    t = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        t = 0;
        for (int i = 0; i < 2; i++) begin
          for (int j = 0; j < 1024; j++) begin
            xr[i][j] = 0; m1r[i][j] = 0; m2r[i][j] = 0; m3r[i][j] = 0;
          end
          exp_dout[i] = 0;
          exp_vld[i]  = 1'b0;
          seen[i]     = 1'b0;
          last_vt[i]  = 0;
        end
      end else begin
        t = t + 1;
        for (int i = 0; i < 2; i++) begin
          int k, kp, kd;
          longint xv;
          k  = t & 1023;
          kp = (t - 1) & 1023;
          kd = (t - DEC[i]) & 1023;
          xv = din ? 1 : -1;
          m1r[i][k] = m1r[i][kp] + xv - xr[i][kd];
          xr[i][k]  = xv;
          m2r[i][k] = m2r[i][kp] + m1r[i][k] - m1r[i][kd];
          m3r[i][k] = m3r[i][kp] + m2r[i][k] - m2r[i][kd];
          exp_vld[i] = 1'b0;
          if (((t - 1) % DEC[i] == 0) && ((t - 1) / DEC[i] >= 4)) begin
            exp_vld[i]  = 1'b1;
            exp_dout[i] = scale16(m3r[i][(t - 4) & 1023], L2[i]);
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus strobe timing checks.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int   act;
        logic av;
        act = (i == 0) ? int'($signed(dout6)) : int'($signed(dout4));
        av  = (i == 0) ? vld6 : vld4;
        chk((i == 0) ? "vld_d64" : "vld_d16", int'(av), int'(exp_vld[i]));
        chk((i == 0) ? "dout_d64" : "dout_d16", act, exp_dout[i]);
        if (av && rst_n) begin
          if (!seen[i]) begin
            chk((i == 0) ? "first_valid_edge_d64" : "first_valid_edge_d16", t, FIRST[i]);
          end else begin
            chk((i == 0) ? "strobe_spacing_d64" : "strobe_spacing_d16", t - last_vt[i], DEC[i]);
          end
          seen[i]       = 1'b1;
          last_vt[i]    = t;
          last_vdout[i] = act;
        end
      end
    end
  end

  task automatic drive_pat(input logic [3:0] pat, input int plen, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      din = pat[i % plen];
    end
  endtask

  // First-order sigma-delta modulation of a 16-bit ramp stepping +16 per clock.
  task automatic drive_ramp(input int n);
    int ramp, err;
    ramp = -32768;
    err  = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      din  = (err >= 0);
      err  = err + ramp - (din ? 32768 : -32768);
      ramp = ramp + 16;
      if (ramp > 32767) ramp = ramp - 65536;
    end
  endtask

  task automatic chk_steady(input string name, input int exp);
    chk({name, "_d64"}, last_vdout[0], exp);
    chk({name, "_d16"}, last_vdout[1], exp);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    last_vdout[0] = 0;
    last_vdout[1] = 0;
    rst_n = 1'b0;
    din   = 1'b0;
    // Reset held with a toggling bitstream; outputs must stay cleared.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      din = ~din;
    end
    chk("reset_dout", int'(dout6), 0);
    chk("reset_vld", int'(vld6), 0);
    @(posedge clk);
    #1;
    din   = 1'b1;
    rst_n = 1'b1;

    drive_pat(4'b0001, 1, 600);
    chk_steady("full_scale_pos", 32767);
    drive_pat(4'b0000, 1, 600);
    chk_steady("full_scale_neg", -32768);
    drive_pat(4'b0001, 2, 600);
    chk_steady("pattern_10", 0);
    drive_pat(4'b0111, 4, 600);
    chk_steady("pattern_1110", 16384);
    drive_pat(4'b0001, 4, 600);
    chk_steady("pattern_1000", -16384);

    drive_ramp(4096);

    // Long full-scale run: integrators wrap many times.
    drive_pat(4'b0001, 1, 20000);
    chk_steady("long_run_pos", 32767);

    // One-cycle reset mid-frame with the decimation counter at 30.
    for (int i = 0; i < 64 && (t % 64) != 30; i++) begin
      @(posedge clk);
      #1;
    end
    chk("midframe_phase", t % 64, 30);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_vdout[0] = 0;
    last_vdout[1] = 0;
    drive_pat(4'b0001, 1, 300);
    chk("rerun_seen_d64", int'(seen[0]), 1);
    chk("rerun_seen_d16", int'(seen[1]), 1);
    chk_steady("after_reset_pos", 32767);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
